scroll_speed_ctrl: RTL and testbench

//  Sequencer for the 8-digit HEX scrolling-text datapath. It owns the scroll period

---
 rtl/scroll_pkg.sv | 19 +
 rtl/key_debounce.sv | 48 ++++
 rtl/scroll_speed_ctrl.sv | 84 ++++++++
 tb/tb_scroll_speed_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
// Shared constants and encodings for the scrolling-text speed sequencer.
package scroll_pkg;
  localparam int DEF_W          = 27;
  localparam int DEF_PERIOD_RST = 49_999_999;
  localparam int DEF_STEP       = 5_000_000;
  localparam int DEF_PERIOD_MIN = 4_999_999;
  localparam int DEF_PERIOD_MAX = 99_999_999;
  localparam int DEF_DEB_CYCLES = 1_000_000;

  localparam int KEY_FAST  = 0;
  localparam int KEY_SLOW  = 1;
  localparam int KEY_PAUSE = 2;
  localparam int KEY_DIR   = 3;

  typedef enum logic {
    S_PAUSE = 1'b0,
    S_RUN   = 1'b1
  } run_state_e;
endpackage

// File: rtl/key_debounce.sv
// Synchronises one active-low push-button, debounces it and emits a one-cycle
// pulse on each accepted press.
module key_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic key_n,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q, level_dly_q, armed_q, press_q;
  logic          samp;

  assign samp  = sync_q[1];
  assign level = level_q;
  assign press = press_q;

  // Synchroniser resets to "pressed" and presses are gated by armed_q, which only
  // sets once a released sample is seen: a key held through reset never reports.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync_q      <= 2'b00;
      cnt_q       <= '0;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      armed_q     <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], key_n};
      level_dly_q <= level_q;
      press_q     <= armed_q & level_dly_q & ~level_q;
      if (samp & level_q) armed_q <= 1'b1;
      if (samp == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_q <= samp;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: rtl/scroll_speed_ctrl.sv
// Scroll sequencer: debounced keys drive speed/pause/direction; a tick counter
// against the period register produces the one-cycle STEP_O strobe.
module scroll_speed_ctrl
  import scroll_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int PERIOD_RST = DEF_PERIOD_RST,
  parameter int STEP       = DEF_STEP,
  parameter int PERIOD_MIN = DEF_PERIOD_MIN,
  parameter int PERIOD_MAX = DEF_PERIOD_MAX,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic         CLOCK_50,
  input  logic         RESET,
  input  logic [3:0]   KEY,
  output logic         STEP_O,
  output logic         DIR_O,
  output logic         RUN_O,
  output logic [W-1:0] PERIOD_O
);
  logic [3:0]   key_level, press;
  logic         unused_level;
  run_state_e   state_q;
  logic [W-1:0] tick_q, period_q, period_d;
  logic [W:0]   dec_w, inc_w;
  logic         step_q, dir_q, dir_pend_q;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [3:0] (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .key_n    (KEY),
    .level    (key_level),
    .press    (press)
  );

  assign unused_level = ^key_level;

  // One extra bit so the decrement shows up negative instead of wrapping.
  assign dec_w = {1'b0, period_q} - (W+1)'(STEP);
  assign inc_w = {1'b0, period_q} + (W+1)'(STEP);

  always_comb begin
    period_d = period_q;
    if (press[KEY_FAST] && !press[KEY_SLOW])
      period_d = (dec_w[W] || dec_w < (W+1)'(PERIOD_MIN)) ? W'(PERIOD_MIN) : dec_w[W-1:0];
    else if (press[KEY_SLOW] && !press[KEY_FAST])
      period_d = (inc_w > (W+1)'(PERIOD_MAX)) ? W'(PERIOD_MAX) : inc_w[W-1:0];
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_RUN;
      tick_q     <= '0;
      period_q   <= W'(PERIOD_RST);
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      dir_pend_q <= 1'b0;
    end else begin
      period_q <= period_d;
      step_q   <= 1'b0;
      if (press[KEY_DIR]) dir_pend_q <= ~dir_pend_q;
      case (state_q)
        S_RUN: begin
          // >= also catches a period shrunk below the running count.
          if (tick_q >= period_q) begin
            step_q <= 1'b1;
            tick_q <= '0;
            dir_q  <= dir_pend_q;
          end else begin
            tick_q <= tick_q + W'(1);
          end
          if (press[KEY_PAUSE]) state_q <= S_PAUSE;
        end
        S_PAUSE: if (press[KEY_PAUSE]) state_q <= S_RUN;
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign STEP_O   = step_q;
  assign DIR_O    = dir_q;
  assign RUN_O    = (state_q == S_RUN);
  assign PERIOD_O = period_q;
endmodule

// File: tb/tb_scroll_speed_ctrl.sv
// Directed bench for scroll_speed_ctrl with small period/debounce parameters.
module tb_scroll_speed_ctrl;
  localparam int W = 27;

  logic         CLOCK_50 = 1'b0;
  logic         RESET    = 1'b1;
  logic [3:0]   KEY      = 4'hF;
  logic         STEP_O, DIR_O, RUN_O;
  logic [W-1:0] PERIOD_O;

  int checks   = 0;
  int failures = 0;
  int n, cnt;

  scroll_speed_ctrl #(
    .W(W), .PERIOD_RST(9), .STEP(2), .PERIOD_MIN(3), .PERIOD_MAX(15), .DEB_CYCLES(4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .KEY      (KEY),
    .STEP_O   (STEP_O),
    .DIR_O    (DIR_O),
    .RUN_O    (RUN_O),
    .PERIOD_O (PERIOD_O)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic       rst;
    logic [3:0] mask;
    int         hold;
    int         exp_period;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(5);
  endtask

  // Cycles (negedges) until STEP_O is seen high; maxc+1 on timeout.
  task automatic wait_step(input int maxc, output int k);
    k = 0;
    do begin
      @(negedge CLOCK_50);
      k++;
    end while (!STEP_O && k <= maxc);
  endtask

  task automatic press_keys(input logic [3:0] mask, input int hold);
    KEY = ~mask;
    tick(hold);
    KEY = 4'hF;
    tick(14);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'b0001, 10, 7};
    vecs[1]  = '{1'b0, 4'b0001, 10, 5};
    vecs[2]  = '{1'b0, 4'b0001, 10, 3};
    vecs[3]  = '{1'b0, 4'b0001, 10, 3};
    vecs[4]  = '{1'b0, 4'b0001, 3,  3};
    vecs[5]  = '{1'b0, 4'b0001, 3,  3};
    vecs[6]  = '{1'b1, 4'b0010, 10, 11};
    vecs[7]  = '{1'b0, 4'b0010, 10, 13};
    vecs[8]  = '{1'b0, 4'b0010, 10, 15};
    vecs[9]  = '{1'b0, 4'b0010, 10, 15};
    vecs[10] = '{1'b0, 4'b0011, 10, 15};
    vecs[11] = '{1'b0, 4'b0001, 10, 13};
    vecs[12] = '{1'b0, 4'b0010, 3,  13};
    vecs[13] = '{1'b0, 4'b0001, 4,  11};

    // Test 1: reset values and free-running strobe spacing
    tick(2);
    chk("rst period", PERIOD_O, 9);
    chk("rst step", STEP_O, 0);
    chk("rst dir", DIR_O, 0);
    chk("rst run", RUN_O, 1);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_step(30, n);
      chk($sformatf("t1 spacing%0d", i), n, 10);
    end
    chk("t1 dir", DIR_O, 0);
    chk("t1 run", RUN_O, 1);

    // Tests 2/3: speed presses, saturation, bounce rejection, simultaneous keys
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      press_keys(vecs[i].mask, vecs[i].hold);
      chk($sformatf("vec%0d period", i), PERIOD_O, vecs[i].exp_period);
    end

    // Test 4: pause with Q=4 held, then resume
    do_reset();
    wait_step(30, n);
    chk("t4 sync", n <= 30, 1);
    tick(6);
    KEY[2] = 1'b0;
    n = 0;
    while (RUN_O && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("t4 pause latency", n, 8);
    chk("t4 run", RUN_O, 0);
    KEY[2] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLOCK_50);
      if (STEP_O) cnt++;
    end
    chk("t4 no step in pause", cnt, 0);
    chk("t4 still paused", RUN_O, 0);
    KEY[2] = 1'b0;
    n = 0;
    while (!RUN_O && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("t4 resumed", RUN_O, 1);
    KEY[2] = 1'b1;
    wait_step(30, n);
    chk("t4 resume to step", n, 6);

    // Test 5: period drops below the running count
    do_reset();
    repeat (3) press_keys(4'b0010, 10);
    chk("t5 period15", PERIOD_O, 15);
    press_keys(4'b0001, 10);
    chk("t5 period13", PERIOD_O, 13);
    wait_step(40, n);
    chk("t5 sync", n <= 40, 1);
    tick(4);
    KEY[0] = 1'b0;
    wait_step(30, n);
    chk("t5 early step", n, 9);
    chk("t5 period11", PERIOD_O, 11);
    KEY[0] = 1'b1;
    wait_step(30, n);
    chk("t5 spacing", n, 12);

    // Test 6: direction key held through reset, then a real press
    KEY[3] = 1'b0;
    tick(3);
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(30);
    wait_step(30, n);
    chk("t6 held step", n <= 30, 1);
    chk("t6 dir held", DIR_O, 0);
    KEY[3] = 1'b1;
    tick(14);
    press_keys(4'b1000, 10);
    wait_step(30, n);
    chk("t6 step", n <= 30, 1);
    chk("t6 dir toggled", DIR_O, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
